// File: rtl/rollo_encrypt_sched_if.sv
// Requester-side and core-side signals of the ROLLO-II job scheduler.
// The slave modport is the scheduler's view; the master modport is the fabric/core view.
interface rollo_encrypt_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 32
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic             done;
  logic [ID_W-1:0]  done_id;
  logic [31:0]      result;
  logic [CNT_W-1:0] cycles;
  logic             timeout;
  logic             busy;
  logic             core_start;
  logic             core_ready;
  logic [31:0]      core_data;

  modport slave (
    input  req, core_ready, core_data,
    output grant, done, done_id, result, cycles, timeout, busy, core_start
  );

  modport master (
    output req, core_ready, core_data,
    input  grant, done, done_id, result, cycles, timeout, busy, core_start
  );
endinterface

// File: rtl/rollo_encrypt_sched.sv
// Round-robin scheduler sharing one ROLLO-II encryption core between N_REQ requesters,
// measuring core runtime and aborting jobs whose core never signals completion.
module rollo_encrypt_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 100000
) (
  input logic                  clk,
  input logic                  rst,
  rollo_encrypt_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ID_W-1:0]  ID_ONE    = {{(ID_W-1){1'b0}}, 1'b1};
  localparam logic [N_REQ-1:0] GRANT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e           state_r, state_nxt_s;
  logic [ID_W-1:0]  ptr_r, ptr_nxt_s;
  logic [ID_W-1:0]  cur_id_r, cur_id_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic             ready_q_r;
  logic [N_REQ-1:0] grant_r, grant_nxt_s;
  logic             core_start_r, core_start_nxt_s;
  logic             done_r, done_nxt_s;
  logic [ID_W-1:0]  done_id_r, done_id_nxt_s;
  logic [31:0]      result_r, result_nxt_s;
  logic [CNT_W-1:0] cycles_r, cycles_nxt_s;
  logic             timeout_r, timeout_nxt_s;
  logic             busy_r, busy_nxt_s;

  logic             found_s;
  logic [ID_W-1:0]  sel_id_s;
  logic [ID_W-1:0]  scan_idx_s;
  logic             ready_rise_s;

  assign cnt_inc_s    = cnt_r + CNT_ONE;
  assign ready_rise_s = bus.core_ready & ~ready_q_r;

  // Round-robin pick: first active request at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    found_s    = 1'b0;
    sel_id_s   = '0;
    scan_idx_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx_s = ID_W'((int'(ptr_r) + i) % N_REQ);
      if (!found_s && bus.req[scan_idx_s]) begin
        found_s  = 1'b1;
        sel_id_s = scan_idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output logic; outputs are loaded one cycle ahead so they are registered.
  always_comb begin
    state_nxt_s      = state_r;
    ptr_nxt_s        = ptr_r;
    cur_id_nxt_s     = cur_id_r;
    cnt_nxt_s        = cnt_r;
    grant_nxt_s      = '0;
    core_start_nxt_s = 1'b0;
    done_nxt_s       = 1'b0;
    done_id_nxt_s    = done_id_r;
    result_nxt_s     = result_r;
    cycles_nxt_s     = cycles_r;
    timeout_nxt_s    = timeout_r;

    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_nxt_s      = ST_START;
          cur_id_nxt_s     = sel_id_s;
          grant_nxt_s      = GRANT_LSB << sel_id_s;
          core_start_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_nxt_s = cnt_inc_s;
        // A ready level held over from before START never completes a job; only a fresh edge does.
        if (ready_rise_s) begin
          result_nxt_s  = bus.core_data;
          cycles_nxt_s  = cnt_inc_s;
          timeout_nxt_s = 1'b0;
          done_nxt_s    = 1'b1;
          done_id_nxt_s = cur_id_r;
          state_nxt_s   = ST_DONE;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          result_nxt_s  = 32'h0000_0000;
          cycles_nxt_s  = TIMEOUT_C;
          timeout_nxt_s = 1'b1;
          done_nxt_s    = 1'b1;
          done_id_nxt_s = cur_id_r;
          state_nxt_s   = ST_DONE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (int'(cur_id_r) == N_REQ - 1) begin
          ptr_nxt_s = '0;
        end else begin
          ptr_nxt_s = cur_id_r + ID_ONE;
        end
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State, pointer, counter and output registers; reset drops any in-flight job silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      cur_id_r     <= '0;
      cnt_r        <= '0;
      ready_q_r    <= 1'b0;
      grant_r      <= '0;
      core_start_r <= 1'b0;
      done_r       <= 1'b0;
      done_id_r    <= '0;
      result_r     <= 32'h0000_0000;
      cycles_r     <= '0;
      timeout_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ptr_r        <= ptr_nxt_s;
      cur_id_r     <= cur_id_nxt_s;
      cnt_r        <= cnt_nxt_s;
      ready_q_r    <= bus.core_ready;
      grant_r      <= grant_nxt_s;
      core_start_r <= core_start_nxt_s;
      done_r       <= done_nxt_s;
      done_id_r    <= done_id_nxt_s;
      result_r     <= result_nxt_s;
      cycles_r     <= cycles_nxt_s;
      timeout_r    <= timeout_nxt_s;
      busy_r       <= busy_nxt_s;
    end
  end

  assign bus.grant      = grant_r;
  assign bus.core_start = core_start_r;
  assign bus.done       = done_r;
  assign bus.done_id    = done_id_r;
  assign bus.result     = result_r;
  assign bus.cycles     = cycles_r;
  assign bus.timeout    = timeout_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_rollo_encrypt_sched.sv
// Scoreboard bench for rollo_encrypt_sched: expected job results are queued at launch
// and checked when done fires; the main thread also plays the encryption core.
module tb_rollo_encrypt_sched;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 50;

  localparam int MODE_NORM  = 0;
  localparam int MODE_HANG  = 1;
  localparam int MODE_STALE = 2;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [31:0]      res;
    logic [CNT_W-1:0] cyc;
    logic             to;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   rr_ptr = 0;

  rollo_encrypt_sched_if #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  rollo_encrypt_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference round-robin: first set bit at or after p, modulo N_REQ.
  function automatic int rr_pick(input logic [N_REQ-1:0] r, input int p);
    int idx;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (p + i) % N_REQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  // Launch check, scoreboard push, core behaviour and done-timing check for one job.
  task automatic run_job(input int mode, input int dly, input logic [31:0] data,
                         input bit drop_req, output int n_wait);
    exp_t             e;
    int               id;
    int               k;
    logic [N_REQ-1:0] one_hot;
    logic [N_REQ-1:0] lsb;
    n_wait = 0;
    while (!bus.core_start && n_wait < 20) begin
      @(negedge clk);
      n_wait++;
    end
    if (!bus.core_start) begin
      check_val("start_seen", 64'd0, 64'd1);
      return;
    end
    id      = rr_pick(bus.req, rr_ptr);
    rr_ptr  = (id + 1) % N_REQ;
    lsb     = 4'b0001;
    one_hot = lsb << id;
    check_val("grant", bus.grant, one_hot);
    check_val("busy", bus.busy, 1'b1);
    case (mode)
      MODE_HANG:  k = TIMEOUT;
      MODE_STALE: k = 13;
      default:    k = dly;
    endcase
    e.id  = ID_W'(id);
    e.res = (mode == MODE_HANG) ? 32'h0 : data;
    e.cyc = CNT_W'(k);
    e.to  = (mode == MODE_HANG);
    sb_q.push_back(e);
    if (drop_req) bus.req = '0;
    case (mode)
      MODE_STALE: begin
        repeat (3) @(negedge clk);
        bus.core_ready = 1'b0;
        repeat (10) @(negedge clk);
        bus.core_data  = data;
        bus.core_ready = 1'b1;
      end
      MODE_HANG: begin
        repeat (TIMEOUT) @(negedge clk);
      end
      default: begin
        repeat (dly) @(negedge clk);
        bus.core_data  = data;
        bus.core_ready = 1'b1;
      end
    endcase
    check_val("done_early", bus.done, 1'b0);
    @(negedge clk);
    check_val("done_at", bus.done, 1'b1);
    bus.core_ready = 1'b0;
  endtask

  // Scoreboard consumer and per-cycle protocol checks.
  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.core_start || (bus.grant != '0))
          check_val("start_grant", {bus.core_start, ($countones(bus.grant) == 1)}, 2'b11);
        if (bus.done) begin
          check_val("excl", bus.grant, 4'b0000);
          if (sb_q.size() == 0) begin
            check_val("done_unexp", 64'd1, 64'd0);
          end else begin
            m = sb_q.pop_front();
            check_val("done_id", bus.done_id, m.id);
            check_val("result", bus.result, m.res);
            check_val("cycles", bus.cycles, m.cyc);
            check_val("timeout", bus.timeout, m.to);
          end
        end
      end
    end
  end

  initial begin : main
    int nw;
    rst            = 1'b1;
    bus.req        = 4'b1111;
    bus.core_ready = 1'b0;
    bus.core_data  = 32'h0;
    repeat (5) @(negedge clk);
    check_val("rst_grant0", bus.grant, 4'b0000);
    check_val("rst_done", bus.done, 1'b0);
    check_val("rst_done_id", bus.done_id, 2'd0);
    check_val("rst_result", bus.result, 32'h0);
    check_val("rst_cycles", bus.cycles, 32'h0);
    check_val("rst_timeout", bus.timeout, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_start0", bus.core_start, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rel_grant", bus.grant, 4'b0001);
    check_val("rel_start", bus.core_start, 1'b1);
    run_job(MODE_NORM, 5, 32'h1234_5678, 1'b1, nw);

    bus.req = 4'b0100;
    run_job(MODE_NORM, 37, 32'hDEAD_BEEF, 1'b1, nw);
    bus.req = 4'b1000;
    run_job(MODE_NORM, 2, $urandom, 1'b1, nw);

    // Held requests 0,1,3 with the pointer back at 0: expected order 0,1,3,0,1,3.
    bus.req = 4'b1011;
    for (int j = 0; j < 6; j++) begin
      run_job(MODE_NORM, (j % 2 == 0) ? 1 : 3 + j, $urandom, (j == 5), nw);
      if (j > 0) check_val("b2b_gap", nw, 2);
    end

    bus.req        = 4'b0001;
    bus.core_ready = 1'b1;
    run_job(MODE_STALE, 0, 32'hCAFE_F00D, 1'b1, nw);

    bus.req = 4'b0010;
    run_job(MODE_HANG, 0, 32'h5555_AAAA, 1'b1, nw);
    bus.req = 4'b0100;
    run_job(MODE_NORM, 7, 32'h0BAD_F00D, 1'b1, nw);

    bus.req = 4'b1000;
    nw = 0;
    while (!bus.core_start && nw < 20) begin
      @(negedge clk);
      nw++;
    end
    check_val("mid_start", bus.core_start, 1'b1);
    bus.req = '0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_busy", bus.busy, 1'b0);
    check_val("mid_cstart", bus.core_start, 1'b0);
    check_val("mid_grant", bus.grant, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      check_val("mid_nodone", bus.done, 1'b0);
    end
    rst     = 1'b0;
    rr_ptr  = 0;
    bus.req = 4'b1111;
    run_job(MODE_NORM, 4, 32'h600D_D00D, 1'b1, nw);

    repeat (3) @(negedge clk);
    check_val("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rollo_encrypt_sched.md
# rollo_encrypt_sched

Round-robin job scheduler that shares one ROLLO-II encryption core among `N_REQ` requesters. It grants one requester at a time and issues the core's single-cycle `start` pulse. It waits for the core's `ready` rising edge, captures the 32-bit `data` word and returns it to the granted requester with a measured cycle count. It sits directly between the requester fabric and the encryption core, and includes a watchdog so a hung core cannot stall the system.

## Interface
- `N_REQ`, default 4: number of requesters (2..16).
- `ID_W`, default 2: width of requester index; must equal clog2(`N_REQ`).
- `CNT_W`, default 32: width of the runtime counter.
- `TIMEOUT`, default 100000: maximum WAIT cycles before a job is aborted (1 ≤ `TIMEOUT` < 2^`CNT_W`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `N_REQ`: level request per requester.
- `grant` out `N_REQ`: one-hot, one-cycle pulse when a requester's job is launched.
- `done` out 1: one-cycle pulse when a job finishes, normally or by timeout.
- `done_id` out `ID_W`: requester index of the finished job; valid while `done`=1, held afterwards.
- `result` out 32: captured core data; valid while `done`=1, held afterwards.
- `cycles` out `CNT_W`: core runtime in clock cycles; valid while `done`=1, held afterwards.
- `timeout` out 1: set together with `done` when the job was aborted; held until the next `done`.
- `busy` out 1: high in every state except IDLE.
- `core_start` out 1: start pulse to the core.
- `core_ready` in 1: core completion flag.
- `core_data` in 32: core output word.

## Operation
States are IDLE, START, WAIT and DONE. All outputs are registered or decoded from state.

- **Reset values:** state=IDLE; `grant`=0; `done`=0; `done_id`=0; `result`=0; `cycles`=0; `timeout`=0; `busy`=0; `core_start`=0; round-robin pointer `ptr`=0; `ready_q`=0.
- **IDLE:**
  - If `req`≠0, select the first set bit scanning `ptr`, `ptr`+1, … modulo `N_REQ`.
  - Register the selection as `cur_id` and go to START.
  - If `req`=0, stay in IDLE.
- **START (exactly 1 cycle):**
  - `core_start`=1.
  - `grant`=one-hot(`cur_id`).
  - Clear the counter to 0.
  - Go to WAIT.
- **WAIT:**
  - The counter increments by 1 every cycle.
  - On a rising edge (`core_ready`=1 and `ready_q`=0): capture `core_data` into `result`, load `cycles` with the incremented count, clear `timeout`, go to DONE.
  - Otherwise, if the incremented count equals `TIMEOUT`: set `result`=0, `cycles`=`TIMEOUT`, `timeout`=1, go to DONE.
  - If an edge and the timeout coincide in the same cycle, the edge wins.
- **DONE (exactly 1 cycle):**
  - `done`=1 and `done_id`=`cur_id`.
  - `ptr` ← (`cur_id`+1) mod `N_REQ`.
  - Go to IDLE.
- **`ready_q`:** sampled from `core_ready` every cycle in all states. A `core_ready` that is already high when START occurs, for example left over from the previous job, does not complete the new job. Completion requires a low-to-high transition observed during WAIT.
- **Request handling:**
  - `req` is only sampled in IDLE.
  - Dropping `req` after `grant` does not cancel the job; `done` still fires.
  - A requester holding `req` high is re-eligible, but the pointer rotation gives every other active requester a turn first.
- **Reset mid-operation:** all state and outputs return to reset values immediately. The in-flight job is dropped with no `done`, and `core_start` is forced to 0.

## Timing
- **Request to launch:** `req` sampled high in IDLE at edge t gives `grant` and `core_start` high during cycle t+1 (START).
- **Runtime count:** with START in cycle s, a `core_ready` rising edge first sampled at the edge ending cycle s+k gives `cycles`=k (k ≥ 1), and `done` is high in cycle s+k+1.
- **Timeout:** with no edge, `done` with `timeout`=1 occurs in cycle s+`TIMEOUT`+1.
- **Pulse spacing:** the minimum spacing between successive `core_start` pulses is 4 cycles (START, WAIT, DONE, IDLE).
- **Back-to-back jobs:** a `req` present during the DONE cycle is seen in the following IDLE cycle.
- **Exclusivity:** `grant` and `done` are never high in the same cycle.
- **Counter width:** `cycles` never wraps, because the `TIMEOUT` bound keeps the counter within `CNT_W` bits.

## Test plan
- **Reset:** assert `rst` for 5 cycles with `req`=4'b1111 → all outputs 0, state IDLE. Release → `grant`=4'b0001 and `core_start`=1 in the same cycle, 1 cycle after the first sampling edge.
- **Single job:** `req`=4'b0100; core model raises `core_ready` 37 cycles after `core_start` with `core_data`=32'hDEADBEEF → `done`=1, `done_id`=2, `result`=32'hDEADBEEF, `cycles`=37, `timeout`=0.
- **Round-robin:** `req`=4'b1011 held high for 6 jobs → grant order is ids 0, 1, 3, 0, 1, 3, with exactly one `core_start` per grant.
- **Stale ready:** leave `core_ready` high across `core_start`, drop it after 3 cycles, raise it after a further 10 cycles → only that later edge completes the job, with `cycles`=13.
- **Timeout:** `TIMEOUT`=50 and `core_ready` held 0 → `done`=1, `timeout`=1, `cycles`=50, `result`=0, in cycle s+51. The next job then completes normally with `timeout`=0.
- **Mid-job reset:** assert `rst` 10 cycles into WAIT → `busy`=0 immediately and no `done`. After release, a new request is granted to id 0 (pointer reset).
